// File: rtl/mem_data_ctrl.sv
// Byte-serial data controller: serves ROB store commits and load-buffer loads over an 8-bit RAM port.
// Stores are buffered one deep and always complete; loads are speculative and die on ROB flush.
module mem_data_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_rst_in,
  input  logic                  rob_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] rob_datactrl_addr_in,
  input  logic [2:0]            rob_datactrl_width_in,
  input  logic [DATA_WIDTH-1:0] rob_datactrl_data_in,
  output logic                  datactrl_rob_en_out,
  input  logic                  lbuffer_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]            lbuffer_datactrl_width_in,
  input  logic                  lbuffer_datactrl_signed_in,
  output logic                  datactrl_lbuffer_en_out,
  output logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, LOAD = 2'd2} state_t;

  state_t                state;
  logic                  st_pend;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [2:0]            st_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;  // store data, or load accumulator
  logic [2:0]            cur_n;
  logic [2:0]            cnt;
  logic                  cur_signed;
  logic                  mem_wr_q;
  logic                  take_direct;
  logic [1:0]            cap_idx;
  logic [DATA_WIDTH-1:0] ld_raw;
  logic [DATA_WIDTH-1:0] ld_ext;

  function automatic logic [2:0] width_bytes(input logic [2:0] w);
    case (w)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign mem_wr_out  = mem_wr_q & rdy_in;
  assign dbg_state   = state;
  assign take_direct = rdy_in && (state == IDLE) && !st_pend;

  // In LOAD, cnt counts edges since accept: issue byte cnt, capture byte cnt-2.
  always_comb begin
    cap_idx = 2'(cnt - 3'd2);
    ld_raw  = cur_data;
    ld_raw[{cap_idx, 3'b000} +: 8] = mem_din_in;
    case (cur_n)
      3'd1:    ld_ext = {{(DATA_WIDTH-8){cur_signed & ld_raw[7]}}, ld_raw[7:0]};
      3'd2:    ld_ext = {{(DATA_WIDTH-16){cur_signed & ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                     <= IDLE;
      st_pend                   <= 1'b0;
      st_addr                   <= '0;
      st_data                   <= '0;
      st_n                      <= 3'd0;
      cur_addr                  <= '0;
      cur_data                  <= '0;
      cur_n                     <= 3'd0;
      cnt                       <= 3'd0;
      cur_signed                <= 1'b0;
      mem_wr_q                  <= 1'b0;
      mem_a_out                 <= '0;
      mem_dout_out              <= 8'h00;
      datactrl_rob_en_out       <= 1'b0;
      datactrl_lbuffer_en_out   <= 1'b0;
      datactrl_lbuffer_data_out <= '0;
    end else begin
      if (rdy_in) begin
        datactrl_rob_en_out     <= 1'b0;
        datactrl_lbuffer_en_out <= 1'b0;
        case (state)
          IDLE: begin
            if (st_pend) begin
              state    <= STORE;
              cur_addr <= st_addr;
              cur_data <= st_data;
              cur_n    <= st_n;
              cnt      <= 3'd0;
              st_pend  <= 1'b0;
            end else if (rob_datactrl_en_in) begin
              state    <= STORE;
              cur_addr <= rob_datactrl_addr_in;
              cur_data <= rob_datactrl_data_in;
              cur_n    <= width_bytes(rob_datactrl_width_in);
              cnt      <= 3'd0;
            end else if (lbuffer_datactrl_en_in && !rob_rst_in) begin
              state      <= LOAD;
              cur_addr   <= lbuffer_datactrl_addr_in;
              cur_data   <= '0;
              cur_n      <= width_bytes(lbuffer_datactrl_width_in);
              cur_signed <= lbuffer_datactrl_signed_in;
              cnt        <= 3'd0;
            end
          end
          STORE: begin
            if (cnt < cur_n) begin
              mem_wr_q     <= 1'b1;
              mem_a_out    <= cur_addr + ADDR_WIDTH'(cnt);
              mem_dout_out <= cur_data[{cnt[1:0], 3'b000} +: 8];
              cnt          <= cnt + 3'd1;
            end else begin
              mem_wr_q            <= 1'b0;
              datactrl_rob_en_out <= 1'b1;
              state               <= IDLE;
            end
          end
          LOAD: begin
            if (rob_rst_in) begin
              state <= IDLE;
            end else begin
              if (cnt < cur_n) mem_a_out <= cur_addr + ADDR_WIDTH'(cnt);
              if (cnt == cur_n + 3'd1) begin
                datactrl_lbuffer_en_out   <= 1'b1;
                datactrl_lbuffer_data_out <= ld_ext;
                state                     <= IDLE;
              end else begin
                if (cnt >= 3'd2) cur_data[{cap_idx, 3'b000} +: 8] <= mem_din_in;
                cnt <= cnt + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == LOAD) begin
        // A paused load restarts from byte 0; a flush still kills it.
        cnt      <= 3'd0;
        cur_data <= '0;
        if (rob_rst_in) state <= IDLE;
      end
      // The one-cycle store pulse must never be lost, even while paused or busy.
      if (rob_datactrl_en_in && !take_direct) begin
        st_pend <= 1'b1;
        st_addr <= rob_datactrl_addr_in;
        st_data <= rob_datactrl_data_in;
        st_n    <= width_bytes(rob_datactrl_width_in);
      end
    end
  end

  a_single_store: assert property (@(posedge clk_in) disable iff (!rst_in)
    rob_datactrl_en_in |-> !(st_pend || state == STORE));

endmodule
